axi4lite_sub_regfile: RTL and testbench
=======================================

Name: axi4lite_sub_regfile

Overview:
- AXI4-Lite subordinate register file on the far side of the team's AXI4-Lite manager; it consumes the manager's read and write transactions.
- Provides a bank of byte-strobed 32-bit control/status registers, exported flat to the fabric with per-register write pulses.
- The last word is a read-only ID register for bring-up.
- Accepts the team manager's handshake style: valids held until the response, BREADY qualified by WREADY.

Parameters:
C_S_AXI_ADDR_WIDTH, 6, byte address width; NUM_REGS = 2**(C_S_AXI_ADDR_WIDTH-2)
C_S_AXI_DATA_WIDTH, 32, data width; fixed at 32, 4 strobe bits
ID_VALUE, 32'h4553_0465, constant returned by word NUM_REGS-1
WREADY_HOLD, 1, 1 = keep WREADY high through W_RESP (manager compatibility)

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESET  in  1  reset, asynchronous, active-high
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 00
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_out  out  NUM_REGS*32  all register contents; word i at bits [32i+31:32i]
reg_wr_stb  out  NUM_REGS  one-cycle pulse the cycle after word i is written

Behaviour:
- Reset (async assert, sync-clocked deassert):
  - all READY/VALID = 0; BRESP, RRESP, RDATA = 0; reg_wr_stb = 0
  - registers 0..NUM_REGS-2 = 0; word NUM_REGS-1 = ID_VALUE
- Readies are registered. They rise on the first clock edge after reset release.
- Reset mid-transaction drops BVALID/RVALID immediately. The pending write is discarded and no register changes.
- Word index = addr[ADDR_WIDTH-1:2]. addr[1:0] is ignored.
- Write FSM W_IDLE -> W_WAIT -> W_RESP:
  - W_IDLE: AWREADY=1, WREADY=1.
    - AWVALID and WVALID together: capture both, commit the write that edge, go to W_RESP.
    - Only one of them valid: capture it, go to W_WAIT.
  - W_WAIT: the ready for the channel already captured = 0; the other stays 1. When the missing one arrives, commit and go to W_RESP.
  - Commit: for each byte b with WSTRB[b]=1, reg[idx][8b+7:8b] <= WDATA byte. reg_wr_stb[idx] pulses the next cycle, also when WSTRB=0.
  - Write to the ID word: no change, no strobe pulse, BRESP=10. All other writes give BRESP=00.
  - W_RESP: BVALID=1, AWREADY=0. WREADY = WREADY_HOLD. W beats presented in W_RESP are ignored.
    - BVALID and BREADY: go to W_IDLE next cycle with both readies back to 1.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID, register RDATA = reg[idx] (pre-write value if a write commits on the same edge). Go to R_DATA.
  - R_DATA: RVALID=1, ARREADY=0. RDATA is stable. RVALID and RREADY: go to R_IDLE.
- Latency:
  - Read: AR handshake at edge N -> RVALID high in cycle N+1.
  - Write: last of AW/W at edge N -> BVALID in cycle N+1.
- Read and write FSMs are fully independent and may complete in the same cycle.
- No back-to-back acceptance: at most one outstanding transaction per direction.

Decomposition:
- Package axi4lite_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - write-FSM state encodings, read-FSM state encodings
- No sub-module. The register array with byte-enable writes stays inline; one module of about 200 lines.

Test Plan:
- Reset: assert S_AXI_ARESET mid-cycle -> all valids/readies 0 at once. After release: AWREADY=WREADY=ARREADY=1 next edge; reg_out word 15 = 32'h45530465, others 0.
- Full write then read: AW=0x08, W=0xDEADBEEF, WSTRB=F, both valids together.
  - BVALID next cycle, BRESP=00; reg_wr_stb[2] pulses once.
  - Read 0x08 -> RVALID one cycle after AR, RDATA=0xDEADBEEF.
- Strobes and split channels:
  - Word 3 = 0x11223344; write 0xAABBCCDD with WSTRB=0101; W presented 3 cycles before AW -> word 3 = 0x11BB33DD.
  - AWREADY stays 1 and WREADY 0 while waiting.
- ID protection: write 0x3C with 0x0 -> BRESP=10, word 15 unchanged, no reg_wr_stb pulse. Read 0x3C -> 0x45530465.
- Team manager in loop: write 0x04 = 0x5, then read 0x04.
  - wrDone and rdDone each assert once; rdData=0x5.
  - No duplicate write from held AWVALID/WVALID.
- Collision and backpressure:
  - Same-edge read and write of 0x10 (old value 0x1, new 0x2) -> RDATA=0x1, then 0x2 on the next read.
  - Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and data stable, readies stay 0.

Source files
------------

// File: rtl/axi4lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_pkg
// Description : Shared AXI4-Lite response codes and FSM state encodings for
//               the subordinate register file.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4lite_pkg;

    // AXI response codes
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    // Write FSM: idle, one of AW/W captured, response pending
    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_WAIT = 2'd1;
    localparam logic [1:0] c_W_RESP = 2'd2;

    // Read FSM: idle, read data pending
    localparam logic [0:0] c_R_IDLE = 1'b0;
    localparam logic [0:0] c_R_DATA = 1'b1;

endpackage : axi4lite_pkg
`default_nettype wire

// File: rtl/axi4lite_sub_regfile.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_sub_regfile
// Description : AXI4-Lite subordinate with byte-strobed 32-bit registers,
//               flat register export, per-word write pulses and a read-only
//               ID word at the top address.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_sub_regfile
    import axi4lite_pkg::*;
#(
    parameter int                            C_S_AXI_ADDR_WIDTH = 6,
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] ID_VALUE           = 32'h4553_0465,
    parameter bit                            WREADY_HOLD        = 1'b1
) (
    input  logic                                  S_AXI_ACLK,
    input  logic                                  S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_AWADDR,
    input  logic                                  S_AXI_AWVALID,
    output logic                                  S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
    input  logic                                  S_AXI_WVALID,
    output logic                                  S_AXI_WREADY,
    output logic [1:0]                            S_AXI_BRESP,
    output logic                                  S_AXI_BVALID,
    input  logic                                  S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_ARADDR,
    input  logic                                  S_AXI_ARVALID,
    output logic                                  S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_RDATA,
    output logic [1:0]                            S_AXI_RRESP,
    output logic                                  S_AXI_RVALID,
    input  logic                                  S_AXI_RREADY,
    output logic [(2**(C_S_AXI_ADDR_WIDTH-2))*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [2**(C_S_AXI_ADDR_WIDTH-2)-1:0]  reg_wr_stb
);

    localparam int c_DW       = C_S_AXI_DATA_WIDTH;
    localparam int c_IDX_W    = C_S_AXI_ADDR_WIDTH - 2;
    localparam int c_NUM_REGS = 2 ** c_IDX_W;

    // Writable storage excludes the ID word, which is a pure constant
    logic [c_DW-1:0]          r_regs  [c_NUM_REGS-1];
    logic [c_DW-1:0]          w_words [c_NUM_REGS];
    logic [c_NUM_REGS-1:0]    r_wr_stb;

    // Write channel state
    logic [1:0]               r_wstate, w_wstate_nxt;
    logic                     r_awready, r_wready, r_bvalid;
    logic                     w_awready_nxt, w_wready_nxt;
    logic [1:0]               r_bresp;
    logic [c_IDX_W-1:0]       r_aw_idx;
    logic [c_DW-1:0]          r_wdata;
    logic [c_DW/8-1:0]        r_wstrb;
    logic                     w_aw_hs, w_w_hs, w_cap_aw, w_cap_w, w_commit;
    logic                     w_commit_is_id;
    logic [c_IDX_W-1:0]       w_commit_idx;
    logic [c_DW-1:0]          w_commit_data;
    logic [c_DW/8-1:0]        w_commit_strb;

    // Read channel state
    logic [0:0]               r_rstate, w_rstate_nxt;
    logic                     r_arready, r_rvalid, w_ar_hs;
    logic [c_DW-1:0]          r_rdata;

    // Byte offset bits carry no meaning for word-aligned registers
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    for (genvar gi = 0; gi < c_NUM_REGS - 1; gi++) begin : g_words
        assign w_words[gi] = r_regs[gi];
    end
    assign w_words[c_NUM_REGS-1] = ID_VALUE;

    for (genvar gi = 0; gi < c_NUM_REGS; gi++) begin : g_reg_out
        assign reg_out[gi*c_DW +: c_DW] = w_words[gi];
    end

    // W beats offered while the response is pending must not be consumed
    assign w_aw_hs = S_AXI_AWVALID && r_awready;
    assign w_w_hs  = S_AXI_WVALID && r_wready && (r_wstate != c_W_RESP);
    assign w_ar_hs = S_AXI_ARVALID && r_arready;

    // Write FSM next state, capture/commit decisions and next readies
    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_cap_aw      = 1'b0;
        w_cap_w       = 1'b0;
        w_commit      = 1'b0;
        w_commit_idx  = r_aw_idx;
        w_commit_data = r_wdata;
        w_commit_strb = r_wstrb;
        case (r_wstate)
            c_W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit      = 1'b1;
                    w_commit_idx  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                    w_commit_data = S_AXI_WDATA;
                    w_commit_strb = S_AXI_WSTRB;
                    w_wstate_nxt  = c_W_RESP;
                end else if (w_aw_hs) begin
                    w_cap_aw     = 1'b1;
                    w_wstate_nxt = c_W_WAIT;
                end else if (w_w_hs) begin
                    w_cap_w      = 1'b1;
                    w_wstate_nxt = c_W_WAIT;
                end
            end
            c_W_WAIT: begin
                // The captured channel is the one whose ready is low
                if (!r_awready && w_w_hs) begin
                    w_commit      = 1'b1;
                    w_commit_data = S_AXI_WDATA;
                    w_commit_strb = S_AXI_WSTRB;
                    w_wstate_nxt  = c_W_RESP;
                end else if (!r_wready && w_aw_hs) begin
                    w_commit     = 1'b1;
                    w_commit_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                    w_wstate_nxt = c_W_RESP;
                end
            end
            c_W_RESP: begin
                if (r_bvalid && S_AXI_BREADY) w_wstate_nxt = c_W_IDLE;
            end
            default: w_wstate_nxt = c_W_IDLE;
        endcase

        w_awready_nxt = 1'b1;
        w_wready_nxt  = 1'b1;
        case (w_wstate_nxt)
            c_W_WAIT: begin
                w_awready_nxt = (r_wstate == c_W_IDLE) ? !w_cap_aw : r_awready;
                w_wready_nxt  = (r_wstate == c_W_IDLE) ? !w_cap_w  : r_wready;
            end
            c_W_RESP: begin
                w_awready_nxt = 1'b0;
                w_wready_nxt  = WREADY_HOLD;
            end
            default: ;
        endcase
    end

    assign w_commit_is_id = (w_commit_idx == c_IDX_W'(c_NUM_REGS - 1));

    // Write FSM state, readies, captured beat and response
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_wstate  <= c_W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= (w_wstate_nxt == c_W_RESP);
            if (w_cap_aw) r_aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            if (w_cap_w) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_commit) r_bresp <= w_commit_is_id ? c_RESP_SLVERR : c_RESP_OKAY;
        end
    end

    // Register array byte-enable update and write pulse generation
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < c_NUM_REGS - 1; i++) r_regs[i] <= '0;
            r_wr_stb <= '0;
        end else begin
            r_wr_stb <= '0;
            if (w_commit && !w_commit_is_id) begin
                for (int b = 0; b < c_DW / 8; b++) begin
                    if (w_commit_strb[b]) r_regs[w_commit_idx][8*b +: 8] <= w_commit_data[8*b +: 8];
                end
                r_wr_stb[w_commit_idx] <= 1'b1;
            end
        end
    end

    // Read FSM next state
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            c_R_IDLE: if (w_ar_hs) w_rstate_nxt = c_R_DATA;
            c_R_DATA: if (r_rvalid && S_AXI_RREADY) w_rstate_nxt = c_R_IDLE;
            default:  w_rstate_nxt = c_R_IDLE;
        endcase
    end

    // Read FSM state, ready/valid and captured read data (pre-write value)
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_rstate  <= c_R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == c_R_IDLE);
            r_rvalid  <= (w_rstate_nxt == c_R_DATA);
            if (w_ar_hs) r_rdata <= w_words[S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]];
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = c_RESP_OKAY;
    assign reg_wr_stb    = r_wr_stb;

endmodule : axi4lite_sub_regfile
`default_nettype wire

// File: tb/tb_axi4lite_sub_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4lite_sub_regfile
// Description : Self-checking bench for axi4lite_sub_regfile with directed
//               scenarios and randomized traffic against a word-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4lite_sub_regfile;

    localparam logic [31:0] c_ID = 32'h4553_0465;

    logic         S_AXI_ACLK = 1'b0;
    logic         S_AXI_ARESET;
    logic [5:0]   S_AXI_AWADDR;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [5:0]   S_AXI_ARADDR;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [511:0] reg_out;
    logic [15:0]  reg_wr_stb;

    int n_assert = 0;
    int n_fail   = 0;
    int stb_total = 0;
    int exp_stb_total = 0;
    logic [31:0] model [16];

    axi4lite_sub_regfile dut (
        .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESET(S_AXI_ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg_out(reg_out), .reg_wr_stb(reg_wr_stb)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    // Count every write pulse seen on any word
    always @(posedge S_AXI_ACLK) stb_total <= stb_total + $countones(reg_wr_stb);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) model[i] = 32'h0;
        model[15] = c_ID;
    endtask

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        if (idx != 15) begin
            for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            exp_stb_total++;
        end
    endtask

    // One write with independent AW/W start delays and B backpressure
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc, idx;
        logic [15:0] exp_stb;
        aw_done = 0; w_done = 0; cyc = 0;
        idx = int'(a[5:2]);
        exp_stb = (idx == 15) ? 16'h0 : (16'h1 << idx);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        while (!(aw_done && w_done)) begin
            S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            S_AXI_WVALID  = !w_done && (cyc >= w_dly);
            @(negedge S_AXI_ACLK);
            if (aw_done != w_done) begin
                chk("wait_awready", S_AXI_AWREADY, !aw_done);
                chk("wait_wready", S_AXI_WREADY, !w_done);
            end
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge S_AXI_ACLK); #1;
            aw_done = aw_done | aw_hs;
            w_done  = w_done | w_hs;
            cyc++;
            if (cyc > 40) begin
                chk("write_accept_timeout", 0, 1);
                break;
            end
        end
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        model_write(idx, d, s);
        chk("b_latency", S_AXI_BVALID, 1'b1);
        chk("bresp", S_AXI_BRESP, (idx == 15) ? 2'b10 : 2'b00);
        chk("wr_stb_pulse", reg_wr_stb, exp_stb);
        for (int i = 0; i < b_dly; i++) begin
            @(negedge S_AXI_ACLK);
            chk("bp_bvalid", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b101);
            chk("bp_bresp", S_AXI_BRESP, (idx == 15) ? 2'b10 : 2'b00);
            @(posedge S_AXI_ACLK); #1;
        end
        S_AXI_BREADY = 1;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_BREADY = 0;
        chk("b_done", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b011);
        chk("reg_out_after_write", reg_out, model_flat());
        chk("stb_count", stb_total, exp_stb_total);
    endtask

    // One read with R backpressure; expected data from the model
    task automatic axi_read(input logic [5:0] a, input int r_dly, input logic [31:0] exp);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
        @(negedge S_AXI_ACLK);
        chk("arready_idle", S_AXI_ARREADY, 1'b1);
        @(posedge S_AXI_ACLK); #1;
        S_AXI_ARVALID = 0;
        chk("r_latency", S_AXI_RVALID, 1'b1);
        chk("rdata", S_AXI_RDATA, exp);
        chk("rresp", S_AXI_RRESP, 2'b00);
        for (int i = 0; i < r_dly; i++) begin
            @(negedge S_AXI_ACLK);
            chk("bp_rvalid", {S_AXI_RVALID, S_AXI_ARREADY}, 2'b10);
            chk("bp_rdata", S_AXI_RDATA, exp);
            @(posedge S_AXI_ACLK); #1;
        end
        S_AXI_RREADY = 1;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_RREADY = 0;
        chk("r_done", {S_AXI_RVALID, S_AXI_ARREADY}, 2'b01);
    endtask

    initial begin
        int wr_done, rd_done, stb_before, idx;
        logic [31:0] rd_data, d;
        logic [3:0]  s;

        S_AXI_ARESET = 1;
        S_AXI_AWADDR = 0; S_AXI_AWVALID = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0;
        S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARADDR = 0; S_AXI_ARVALID = 0;
        S_AXI_RREADY = 0;
        model_reset();

        // Reset state and readies rising one edge after release
        repeat (2) @(posedge S_AXI_ACLK); #1;
        chk("rst_handshake", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID}, 5'b0);
        S_AXI_ARESET = 0;
        #1;
        chk("rst_release_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        @(posedge S_AXI_ACLK); #1;
        chk("readies_after_release", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        chk("reset_regs", reg_out, model_flat());
        chk("reset_id_word", reg_out[511:480], 32'h45530465);
        chk("reset_stb", reg_wr_stb, 16'h0);

        // Full write then read
        axi_write(6'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        axi_read(6'h08, 0, 32'hDEADBEEF);

        // Byte strobes with W arriving three cycles before AW
        axi_write(6'h0C, 32'h11223344, 4'hF, 0, 0, 0);
        axi_write(6'h0C, 32'hAABBCCDD, 4'b0101, 3, 0, 0);
        chk("strobe_merge", reg_out[127:96], 32'h11BB33DD);
        axi_write(6'h14, 32'h01020304, 4'h0, 0, 2, 0);

        // ID word protection
        axi_write(6'h3C, 32'h0, 4'hF, 0, 0, 0);
        chk("id_unchanged", reg_out[511:480], c_ID);
        axi_read(6'h3C, 0, 32'h45530465);

        // Manager-style write: valids held until response, BREADY gated by WREADY
        S_AXI_AWADDR = 6'h04; S_AXI_WDATA = 32'h5; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
        wr_done = 0;
        for (int c = 0; c < 20 && wr_done == 0; c++) begin
            @(negedge S_AXI_ACLK);
            if (S_AXI_BVALID && S_AXI_WREADY) begin
                S_AXI_BREADY = 1;
                @(posedge S_AXI_ACLK); #1;
                S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
                wr_done++;
            end else begin
                @(posedge S_AXI_ACLK); #1;
            end
        end
        model_write(1, 32'h5, 4'hF);
        repeat (3) @(posedge S_AXI_ACLK); #1;
        chk("mgr_wr_done", wr_done, 1);
        chk("mgr_no_dup_write", stb_total, exp_stb_total);
        S_AXI_ARADDR = 6'h04; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
        rd_done = 0; rd_data = 0;
        for (int c = 0; c < 20 && rd_done == 0; c++) begin
            @(negedge S_AXI_ACLK);
            if (S_AXI_RVALID) begin
                rd_data = S_AXI_RDATA;
                rd_done++;
                @(posedge S_AXI_ACLK); #1;
                S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
            end else begin
                @(posedge S_AXI_ACLK); #1;
            end
        end
        chk("mgr_rd_done", rd_done, 1);
        chk("mgr_rd_data", rd_data, 32'h5);

        // Same-edge read and write of one word returns the old value
        axi_write(6'h10, 32'h1, 4'hF, 0, 0, 0);
        S_AXI_AWADDR = 6'h10; S_AXI_WDATA = 32'h2; S_AXI_WSTRB = 4'hF;
        S_AXI_ARADDR = 6'h10;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        chk("collide_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
        chk("collide_rdata_old", S_AXI_RDATA, 32'h1);
        S_AXI_BREADY = 1; S_AXI_RREADY = 1;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_BREADY = 0; S_AXI_RREADY = 0;
        model_write(4, 32'h2, 4'hF);
        axi_read(6'h10, 0, 32'h2);

        // Backpressure on both response channels
        axi_write(6'h18, 32'hCAFE0001, 4'hF, 1, 0, 5);
        axi_read(6'h18, 5, 32'hCAFE0001);

        // Randomized traffic against the word model
        for (int n = 0; n < 40; n++) begin
            idx = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write({idx[3:0], 2'($urandom_range(0, 3))}, d, s,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)));
            end else begin
                axi_read({idx[3:0], 2'($urandom_range(0, 3))}, int'($urandom_range(0, 2)), model[idx]);
            end
        end

        // Reset asserted mid-cycle with both responses pending
        stb_before = stb_total;
        S_AXI_AWADDR = 6'h20; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 6'h20;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        chk("pre_reset_pending", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
        #2;
        S_AXI_ARESET = 1;
        #1;
        chk("async_reset_outputs",
            {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RDATA, reg_wr_stb},
            '0);
        model_reset();
        chk("async_reset_regs", reg_out, model_flat());
        @(posedge S_AXI_ACLK); #1;
        S_AXI_ARESET = 0;
        @(posedge S_AXI_ACLK); #1;
        chk("readies_after_rerelease", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        chk("no_stb_through_reset", stb_total, stb_before);
        axi_read(6'h20, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_axi4lite_sub_regfile
`default_nettype wire
